// File: rtl/vitals_frame_rx_if.sv
// Sensor-link bundle: serial bit stream in, validated parallel readings and status out.
// The master drives the serial side; the receiver (slave) drives the readings and status.
interface vitals_frame_rx_if #(
   parameter int unsigned W = 10
);
   logic         s_data;
   logic         s_valid;
   logic         s_start;
   logic [W-1:0] age;
   logic [W-1:0] bloodP;
   logic [W-1:0] breathR;
   logic [W-1:0] heartB;
   logic         frame_ok;
   logic         frame_err;
   logic         busy;
   logic [7:0]   err_cnt;

   modport master (
      output s_data, s_valid, s_start,
      input  age, bloodP, breathR, heartB, frame_ok, frame_err, busy, err_cnt
   );

   modport slave (
      input  s_data, s_valid, s_start,
      output age, bloodP, breathR, heartB, frame_ok, frame_err, busy, err_cnt
   );
endinterface

// File: rtl/vitals_frame_rx.sv
// Vital-sign frame receiver: deserialises four W-bit readings plus an 8-bit checksum,
// and publishes the readings atomically only when the checksum matches.
module vitals_frame_rx #(
   parameter int unsigned W       = 10,
   parameter int unsigned TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst_n,
   vitals_frame_rx_if.slave  rx
);

   localparam int unsigned DataBits = 4 * W;
   localparam int unsigned CntW     = $clog2(DataBits);
   localparam int unsigned IdleW    = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0]  LastData = CntW'(DataBits - 1);
   localparam logic [CntW-1:0]  LastCsum = CntW'(7);
   localparam logic [IdleW-1:0] LastIdle = IdleW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StData, StCsum} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [IdleW-1:0]     idle_cnt_q, idle_cnt_d;
   logic [DataBits-1:0]  data_q, data_d;
   logic [7:0]           csum_q, csum_d;
   logic [W-1:0]         age_q, age_d, blood_q, blood_d;
   logic [W-1:0]         breath_q, breath_d, heart_q, heart_d;
   logic                 ok_q, ok_d, err_q, err_d, busy_q, busy_d;
   logic [7:0]           err_cnt_q, err_cnt_d;

   logic [W+1:0]         sum;
   logic [7:0]           csum_rx;
   logic                 take_start;

   assign take_start = rx.s_valid & rx.s_start;
   assign csum_rx    = {csum_q[6:0], rx.s_data};
   assign sum        = {2'b00, data_q[4*W-1:3*W]} + {2'b00, data_q[3*W-1:2*W]}
                     + {2'b00, data_q[2*W-1:W]}   + {2'b00, data_q[W-1:0]};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      data_d     = data_q;
      csum_d     = csum_q;
      age_d      = age_q;
      blood_d    = blood_q;
      breath_d   = breath_q;
      heart_d    = heart_q;
      ok_d       = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (take_start) begin
               state_d    = StData;
               data_d     = {{(DataBits - 1){1'b0}}, rx.s_data};
               bit_cnt_d  = CntW'(1);
               idle_cnt_d = '0;
            end
         end
         StData, StCsum: begin
            if (take_start) begin
               // A fresh start aborts the current frame and becomes bit 0 of the next.
               err_d      = 1'b1;
               state_d    = StData;
               data_d     = {{(DataBits - 1){1'b0}}, rx.s_data};
               bit_cnt_d  = CntW'(1);
               idle_cnt_d = '0;
            end else if (rx.s_valid) begin
               idle_cnt_d = '0;
               if (state_q == StData) begin
                  data_d = {data_q[DataBits-2:0], rx.s_data};
                  if (bit_cnt_q == LastData) begin
                     state_d   = StCsum;
                     bit_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  csum_d = csum_rx;
                  if (bit_cnt_q == LastCsum) begin
                     state_d = StIdle;
                     if (sum[7:0] == csum_rx) begin
                        ok_d     = 1'b1;
                        age_d    = data_q[4*W-1:3*W];
                        blood_d  = data_q[3*W-1:2*W];
                        breath_d = data_q[2*W-1:W];
                        heart_d  = data_q[W-1:0];
                     end else begin
                        err_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end else if (idle_cnt_q == LastIdle) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d    = (state_d != StIdle);
      err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         idle_cnt_q <= '0;
         data_q     <= '0;
         csum_q     <= '0;
         age_q      <= '0;
         blood_q    <= '0;
         breath_q   <= '0;
         heart_q    <= '0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         data_q     <= data_d;
         csum_q     <= csum_d;
         age_q      <= age_d;
         blood_q    <= blood_d;
         breath_q   <= breath_d;
         heart_q    <= heart_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign rx.age       = age_q;
   assign rx.bloodP    = blood_q;
   assign rx.breathR   = breath_q;
   assign rx.heartB    = heart_q;
   assign rx.frame_ok  = ok_q;
   assign rx.frame_err = err_q;
   assign rx.busy      = busy_q;
   assign rx.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_vitals_frame_rx.sv
// Bench for vitals_frame_rx: directed frames feed a scoreboard of expected pulses,
// and a negedge monitor pops and compares each frame_ok/frame_err event.
module tb_vitals_frame_rx;
   localparam int unsigned W = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   vitals_frame_rx_if #(.W(W)) bus ();

   vitals_frame_rx #(.W(W), .TIMEOUT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           ok;
      bit           busy;
      logic [W-1:0] a, b, c, d;
      logic [7:0]   ec;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] m_a = '0, m_b = '0, m_c = '0, m_d = '0;
   int           exp_ec = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic push_ok(input logic [W-1:0] a, b, c, d);
      exp_t e;
      m_a = a; m_b = b; m_c = c; m_d = d;
      e = '{ok: 1'b1, busy: 1'b0, a: a, b: b, c: c, d: d, ec: 8'(exp_ec)};
      sb.push_back(e);
   endtask

   task automatic push_err(input bit busy_after);
      exp_t e;
      exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
      e = '{ok: 1'b0, busy: busy_after, a: m_a, b: m_b, c: m_c, d: m_d, ec: 8'(exp_ec)};
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic d, input logic start);
      bus.s_data  = d;
      bus.s_valid = 1'b1;
      bus.s_start = start;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_start = 1'b0;
   endtask

   // gapped=1 alternates one idle cycle per bit with a 10-cycle gap every 8 bits.
   task automatic send_frame(input logic [W-1:0] a, b, c, d, input logic [7:0] cs,
                             input bit gapped, input int nbits);
      logic [4*W+7:0] v;
      v = {a, b, c, d, cs};
      for (int i = 0; i < nbits; i++) begin
         send_bit(v[4*W+7-i], i == 0);
         if (gapped) idle((i % 8 == 7) ? 10 : 1);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_age"}, 32'(bus.age), 0);
      check({tag, "_bloodP"}, 32'(bus.bloodP), 0);
      check({tag, "_breathR"}, 32'(bus.breathR), 0);
      check({tag, "_heartB"}, 32'(bus.heartB), 0);
      check({tag, "_frame_ok"}, 32'(bus.frame_ok), 0);
      check({tag, "_frame_err"}, 32'(bus.frame_err), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (bus.frame_ok || bus.frame_err)) begin
         check("ok_err_exclusive", 32'(bus.frame_ok & bus.frame_err), 0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: ok=%0b err=%0b, no event expected",
                     bus.frame_ok, bus.frame_err);
         end else begin
            e = sb.pop_front();
            check("pulse_is_ok", 32'(bus.frame_ok), 32'(e.ok));
            check("pulse_age", 32'(bus.age), 32'(e.a));
            check("pulse_bloodP", 32'(bus.bloodP), 32'(e.b));
            check("pulse_breathR", 32'(bus.breathR), 32'(e.c));
            check("pulse_heartB", 32'(bus.heartB), 32'(e.d));
            check("pulse_err_cnt", 32'(bus.err_cnt), 32'(e.ec));
            check("pulse_busy", 32'(bus.busy), 32'(e.busy));
         end
      end
   end

   initial begin
      bus.s_data  = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_start = 1'b0;
      rst_n       = 1'b0;
      idle(3);
      rst_n = 1'b1;
      check_outputs_zero("reset");

      // Bits without a start in idle are ignored silently.
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      check("stray_bits_busy", 32'(bus.busy), 0);

      // Good frame: 25+130+19+80 = 254.
      push_ok(10'd25, 10'd130, 10'd19, 10'd80);
      send_frame(10'd25, 10'd130, 10'd19, 10'd80, 8'hFE, 1'b0, 48);
      check("t1_ok_latency", 32'(bus.frame_ok), 1);
      idle(2);

      // Bad checksum: outputs hold the previous good frame.
      push_err(1'b0);
      send_frame(10'd25, 10'd130, 10'd19, 10'd80, 8'hFF, 1'b0, 48);
      check("t2_err_latency", 32'(bus.frame_err), 1);
      idle(2);

      // Gapped stream, then a 64-cycle stall mid-frame.
      push_ok(10'd25, 10'd130, 10'd19, 10'd80);
      send_frame(10'd25, 10'd130, 10'd19, 10'd80, 8'hFE, 1'b1, 48);
      idle(2);
      send_frame(10'd25, 10'd130, 10'd19, 10'd80, 8'hFE, 1'b0, 20);
      idle(63);
      check("t3_busy_before_timeout", 32'(bus.busy), 1);
      push_err(1'b0);
      idle(1);
      check("t3_busy_after_timeout", 32'(bus.busy), 0);
      check("t3_timeout_err", 32'(bus.frame_err), 1);
      idle(2);

      // Abort after 20 bits; new frame 70+140+20+66 = 296 -> 0x28.
      push_err(1'b1);
      push_ok(10'd70, 10'd140, 10'd20, 10'd66);
      send_frame(10'd25, 10'd130, 10'd19, 10'd80, 8'hFE, 1'b0, 20);
      send_frame(10'd70, 10'd140, 10'd20, 10'd66, 8'h28, 1'b0, 48);
      idle(2);

      // Reset mid-frame (60+120+16+72 = 268 -> 0x0C).
      send_frame(10'd60, 10'd120, 10'd16, 10'd72, 8'h0C, 1'b0, 30);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      m_a = '0; m_b = '0; m_c = '0; m_d = '0;
      exp_ec = 0;
      check_outputs_zero("t5_reset");
      idle(2);
      push_ok(10'd60, 10'd120, 10'd16, 10'd72);
      send_frame(10'd60, 10'd120, 10'd16, 10'd72, 8'h0C, 1'b0, 48);
      idle(2);

      // Back-to-back bad frames saturate the error counter.
      for (int n = 0; n < 300; n++) begin
         push_err(1'b0);
         send_frame(10'd60, 10'd120, 10'd16, 10'd72, 8'h0D, 1'b0, 48);
      end
      idle(2);
      check("t6_err_cnt_saturated", 32'(bus.err_cnt), 255);

      idle(5);
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
